// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//
// UART receiver (8N1, optionally 8E1) feeding a small first-word-fall-through
// receive FIFO. It watches the serial stream from the management SoC UART and
// presents decoded bytes on a valid/ready interface.
//
// Build option:
//   UART_RX_PARITY_EN  when defined, an even-parity bit is expected between D7
//                      and the stop bit, and parity_err is live. When undefined
//                      the receiver is 8N1 only and parity_err is tied to 0.
//
// Ports:
//   core_clk    system clock
//   core_rstn   asynchronous active-low reset
//   enable      receiver enable; low forces the FSM to IDLE (FIFO kept)
//   divisor     core_clk cycles per bit; values below 4 behave as 4
//   ser_rx      asynchronous serial input, idle high
//   rx_data     FIFO head byte, 0 when empty
//   rx_valid    FIFO not empty
//   rx_ready    consumer accepts the head byte
//   rx_level    FIFO occupancy
//   busy        FSM not in IDLE
//   frame_err   sticky: stop bit sampled low
//   parity_err  sticky: parity mismatch
//   overrun     sticky: good byte arrived with the FIFO full
//   clear_err   pulse clearing all sticky flags (a same-cycle set wins)

module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                     core_clk,
  input  logic                     core_rstn,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         divisor,
  input  logic                     ser_rx,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     overrun,
  input  logic                     clear_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_next;
  logic             sync1, rx_s, prev_rx;
  logic [DIV_W-1:0] cnt, cnt_next;
  logic [DIV_W-1:0] d_eff, full_load, half_load;
  logic [7:0]       shift, shift_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic             expired;
  logic             push, set_frame;
`ifdef UART_RX_PARITY_EN
  logic             par_bad, par_bad_next, set_par;
`endif

  logic [7:0]       mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             full, pop, push_ok, set_ovr;

  // Clamp the divisor so the half-bit start delay is never shorter than 2.
  assign d_eff     = (divisor < DIV_W'(4)) ? DIV_W'(4) : divisor;
  assign full_load = d_eff - DIV_W'(1);
  assign half_load = (d_eff >> 1) - DIV_W'(1);
  assign expired   = (cnt == '0);

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  // All reset high so a line idling high produces no edge after reset.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      prev_rx <= 1'b1;
    end else begin
      sync1   <= ser_rx;
      rx_s    <= sync1;
      prev_rx <= rx_s;
    end
  end

  // FSM and bit-timing registers.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_next;
`endif
    end
  end

  // Next-state logic. Each state counts down to zero and samples rx_s once.
  // A break leaves prev_rx low, so no new start is seen until the line rises.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    push         = 1'b0;
    set_frame    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad;
    set_par      = 1'b0;
`endif
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (prev_rx && !rx_s) begin
            state_next = START;
            cnt_next   = half_load;
          end
        end
        START: begin
          if (!expired) begin
            cnt_next = cnt - DIV_W'(1);
          end else if (!rx_s) begin
            state_next   = DATA;
            cnt_next     = full_load;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
        DATA: begin
          if (!expired) begin
            cnt_next = cnt - DIV_W'(1);
          end else begin
            shift_next = {rx_s, shift[7:1]};
            cnt_next   = full_load;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              bit_idx_next = bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (!expired) begin
            cnt_next = cnt - DIV_W'(1);
          end else begin
            par_bad_next = rx_s ^ (^shift);
            state_next   = STOP;
            cnt_next     = full_load;
          end
        end
`endif
        STOP: begin
          if (!expired) begin
            cnt_next = cnt - DIV_W'(1);
          end else begin
            state_next = IDLE;
            if (!rx_s) begin
              set_frame = 1'b1;
            end else begin
`ifdef UART_RX_PARITY_EN
              push    = !par_bad;
              set_par = par_bad;
`else
              push    = 1'b1;
`endif
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // FIFO control. Pointers carry one extra wrap bit so full and empty differ.
  assign rx_level = wptr - rptr;
  assign rx_valid = (wptr != rptr);
  assign full     = (rx_level == (AW+1)'(DEPTH));
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = push && (!full || pop);
  assign set_ovr  = push && full && !pop;
  assign rx_data  = rx_valid ? mem[rptr[AW-1:0]] : 8'h00;

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + (AW+1)'(1);
      if (pop)     rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage has no reset; rx_data is masked to 0 while the FIFO is empty.
  always_ff @(posedge core_clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= shift;
  end

  // Sticky error flags: a set in the same cycle as clear_err takes priority.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (set_frame)      frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
      if (set_ovr)        overrun   <= 1'b1;
      else if (clear_err) overrun   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn)     parity_err <= 1'b0;
    else if (set_par)   parity_err <= 1'b1;
    else if (clear_err) parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//
// Scoreboard bench for uart_rx_fifo. Expected bytes are queued as frames are
// sent; a monitor pops and compares on every valid/ready handshake. Direct
// checks cover reset values, sample timing, overrun, framing/break, glitch,
// enable/reset mid-frame and (when compiled with UART_RX_PARITY_EN) parity.

module tb_uart_rx_fifo;

  localparam int DEPTH = 4;

  logic        core_clk = 1'b0;
  logic        core_rstn = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] divisor = 16'd8;
  logic        ser_rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [2:0]  rx_level;
  logic        busy;
  logic        frame_err;
  logic        parity_err;
  logic        overrun;
  logic        clear_err = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          bit_cycles = 8;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_byte;
  logic        busy_seen;

  uart_rx_fifo #(.DEPTH(DEPTH), .DIV_W(16)) dut (
    .core_clk   (core_clk),
    .core_rstn  (core_rstn),
    .enable     (enable),
    .divisor    (divisor),
    .ser_rx     (ser_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_level   (rx_level),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .clear_err  (clear_err)
  );

  always #5 core_clk = ~core_clk;

  // Compare one value; every call counts as a check.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Send one frame, each bit held bit_cycles clocks. Leaves the line at the
  // stop-bit level. Called and returns at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input logic par_flip);
    ser_rx = 1'b0;
    repeat (bit_cycles) @(posedge core_clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      ser_rx = data[i];
      repeat (bit_cycles) @(posedge core_clk);
      #1;
    end
`ifdef UART_RX_PARITY_EN
    ser_rx = (^data) ^ par_flip;
    repeat (bit_cycles) @(posedge core_clk);
    #1;
`else
    if (par_flip) $display("[TB] parity flip ignored in 8N1 build");
`endif
    ser_rx = stop_bit;
    repeat (bit_cycles) @(posedge core_clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge core_clk);
    #1;
  endtask

  task automatic popOne();
    rx_ready = 1'b1;
    idleCycles(1);
    rx_ready = 1'b0;
  endtask

  task automatic pulseClear();
    clear_err = 1'b1;
    idleCycles(1);
    clear_err = 1'b0;
  endtask

  // Monitor: every accepted head byte is compared against the scoreboard.
  always @(negedge core_clk) begin
    if (core_rstn && rx_valid && rx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_byte: got 0x%0h expected none", rx_data);
      end else begin
        exp_byte = exp_q.pop_front();
        if (rx_data !== exp_byte) begin
          errors++;
          $display("[TB] FAIL scoreboard_byte: got 0x%0h expected 0x%0h",
                   rx_data, exp_byte);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    idleCycles(2);
    checkOutput("rst_rx_data", rx_data, 8'h00);
    checkOutput("rst_rx_valid", rx_valid, 1'b0);
    checkOutput("rst_rx_level", rx_level, 3'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_flags", {frame_err, parity_err, overrun}, 3'b000);
    core_rstn = 1'b1;
    idleCycles(2);
    enable = 1'b1;
    idleCycles(4);

    // Single byte with sample-point timing: stop sample at cycle 76 after
    // the detect cycle, which is 78 edges after the start bit is driven.
    exp_q.push_back(8'hA5);
    fork
      applyStimulus(8'hA5, 1'b1, 1'b0);
      begin
        repeat (40) @(posedge core_clk);
        #1 checkOutput("busy_mid_frame", busy, 1'b1);
        repeat (38) @(posedge core_clk);
        #1 checkOutput("valid_before_stop", rx_valid, 1'b0);
        @(posedge core_clk);
        #1 checkOutput("valid_after_stop", rx_valid, 1'b1);
      end
    join
    checkOutput("single_data", rx_data, 8'hA5);
    checkOutput("single_level", rx_level, 3'd1);
    popOne();
    checkOutput("single_valid_after_pop", rx_valid, 1'b0);
    checkOutput("single_data_after_pop", rx_data, 8'h00);

    // Overrun: five back-to-back bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      applyStimulus(8'(i), 1'b1, 1'b0);
    end
    idleCycles(4);
    checkOutput("ovr_level", rx_level, 3'd4);
    checkOutput("ovr_flag", overrun, 1'b1);
    checkOutput("ovr_head", rx_data, 8'h01);
    rx_ready = 1'b1;
    idleCycles(4);
    rx_ready = 1'b0;
    checkOutput("ovr_drained_valid", rx_valid, 1'b0);
    checkOutput("ovr_drained_level", rx_level, 3'd0);
    pulseClear();
    checkOutput("ovr_cleared", overrun, 1'b0);

    // Framing error followed by a 30-bit break
    applyStimulus(8'h3C, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("frame_flag", frame_err, 1'b1);
    checkOutput("frame_level", rx_level, 3'd0);
    busy_seen = 1'b0;
    for (int i = 0; i < 30 * 8; i++) begin
      idleCycles(1);
      if (busy) busy_seen = 1'b1;
    end
    checkOutput("break_no_start", busy_seen, 1'b0);
    checkOutput("break_no_byte", rx_valid, 1'b0);
    ser_rx = 1'b1;
    idleCycles(16);
    exp_q.push_back(8'h55);
    applyStimulus(8'h55, 1'b1, 1'b0);
    idleCycles(2);
    checkOutput("after_break_level", rx_level, 3'd1);
    checkOutput("frame_sticky", frame_err, 1'b1);
    popOne();
    pulseClear();
    checkOutput("frame_cleared", frame_err, 1'b0);

    // Glitch: 2-cycle low pulse with D=16 is a false start
    divisor = 16'd16;
    bit_cycles = 16;
    idleCycles(2);
    ser_rx = 1'b0;
    idleCycles(2);
    ser_rx = 1'b1;
    idleCycles(1);
    checkOutput("glitch_busy_rise", busy, 1'b1);
    idleCycles(20);
    checkOutput("glitch_busy_fall", busy, 1'b0);
    checkOutput("glitch_level", rx_level, 3'd0);
    checkOutput("glitch_flags", {frame_err, parity_err, overrun}, 3'b000);
    divisor = 16'd8;
    bit_cycles = 8;
    idleCycles(2);

    // Enable dropped during data bit 4; the stored byte must survive
    exp_q.push_back(8'h22);
    applyStimulus(8'h22, 1'b1, 1'b0);
    idleCycles(2);
    fork
      applyStimulus(8'hF0, 1'b1, 1'b0);
      begin
        repeat (44) @(posedge core_clk);
        #1 enable = 1'b0;
        @(posedge core_clk);
        #1 checkOutput("en_off_busy", busy, 1'b0);
      end
    join
    idleCycles(16);
    enable = 1'b1;
    idleCycles(4);
    checkOutput("en_off_level", rx_level, 3'd1);
    checkOutput("en_off_data", rx_data, 8'h22);
    checkOutput("en_off_flags", {frame_err, parity_err, overrun}, 3'b000);
    popOne();
    checkOutput("en_off_popped", rx_valid, 1'b0);

    // Asynchronous reset during data bit 4 with a byte held in the FIFO
    applyStimulus(8'h33, 1'b1, 1'b0);
    idleCycles(2);
    checkOutput("pre_rst_data", rx_data, 8'h33);
    fork
      applyStimulus(8'h9A, 1'b1, 1'b0);
      begin
        repeat (44) @(posedge core_clk);
        #1 checkOutput("pre_rst_busy", busy, 1'b1);
        #2 core_rstn = 1'b0;
        #1;
        checkOutput("arst_data", rx_data, 8'h00);
        checkOutput("arst_valid", rx_valid, 1'b0);
        checkOutput("arst_level", rx_level, 3'd0);
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_flags", {frame_err, parity_err, overrun}, 3'b000);
      end
    join
    idleCycles(4);
    core_rstn = 1'b1;
    idleCycles(4);
    checkOutput("post_rst_valid", rx_valid, 1'b0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit is 1
    exp_q.push_back(8'h07);
    applyStimulus(8'h07, 1'b1, 1'b0);
    idleCycles(2);
    checkOutput("par_ok_flag", parity_err, 1'b0);
    popOne();
    applyStimulus(8'h07, 1'b1, 1'b1);
    idleCycles(2);
    checkOutput("par_bad_flag", parity_err, 1'b1);
    checkOutput("par_bad_level", rx_level, 3'd0);
`else
    checkOutput("par_tied_low", parity_err, 1'b0);
`endif

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Synthesizable UART receiver with a small receive FIFO. It consumes the serial stream driven on `ser_tx` by the management SoC's UART, decodes 8N1 frames (optionally 8E1), and presents bytes on a valid/ready interface. It sits directly downstream of the SoC UART transmitter, as a loopback or on-chip monitor. It lets benches and user-area logic check UART output without a behavioural `tbuart`.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of two, minimum 2.
- `DIV_W`, 16: width of `divisor`.

Ports:
- `core_clk`  in  1  system clock.
- `core_rstn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `enable`  in  1  receiver enable. Low forces the FSM to IDLE; FIFO contents are kept.
- `divisor`  in  DIV_W  `core_clk` cycles per bit (D). Values below 4 are treated as 4. Must be static while `busy`.
- `ser_rx`  in  1  serial input, asynchronous, idle high.
- `rx_data`  out  8  FIFO head byte; 0 when the FIFO is empty.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head byte.
- `rx_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `busy`  out  1  FSM not in IDLE.
- `frame_err`  out  1  sticky: a stop bit was sampled as 0.
- `parity_err`  out  1  sticky: parity mismatch. Tied to 0 without `UART_RX_PARITY_EN`.
- `overrun`  out  1  sticky: a good byte arrived while the FIFO was full.
- `clear_err`  in  1  one-cycle pulse that clears all sticky flags.

## Operation

- **Input synchronizer.** `ser_rx` passes through a 2-FF synchronizer; both flops reset to 1. The FSM sees `rx_s`.
- **Bit counter.** A down-counter is loaded with D-1 (or floor(D/2)-1 for the start bit). A sample is taken when it reaches 0.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: a falling edge on `rx_s` (previous 1, current 0) with `enable`=1 moves to START and loads floor(D/2)-1.
  - START: at expiry, sample `rx_s`.
    - 0: move to DATA and load D-1.
    - 1: false start; return to IDLE with no flags set.
  - DATA: sample a bit at each expiry, LSB first, into a shift register. After the 8th bit, move to PARITY if compiled in, otherwise STOP.
  - PARITY: sample one bit, compare against even parity of the data, latch a mismatch result, then move to STOP.
  - STOP: at expiry, sample `rx_s`, then always return to IDLE.
    - 1 with no parity mismatch: push the byte.
    - 1 with a parity mismatch: set `parity_err` and discard the byte.
    - 0: set `frame_err` and discard the byte. A break (line held low) produces no new start until `rx_s` returns high.
- **`enable` deasserted mid-frame.** The FSM returns to IDLE on the next cycle. The partial byte is dropped and no flags are set.
- **FIFO.** First-word-fall-through circular buffer with wrap-around pointers; `rx_data` is the head entry.
  - A pop occurs when `rx_valid & rx_ready`.
  - Push while full without a same-cycle pop: the byte is dropped, `overrun` is set, and stored data is unchanged.
  - Push and pop in the same cycle while full: both succeed and the level stays at DEPTH.
  - Push and pop in the same cycle while empty: the push succeeds and the pop does not occur (`rx_valid` was 0).
- **Sticky flags.** A same-cycle set and `clear_err` results in the flag being set.

## Timing

- **Reset values:** `rx_data`=0, `rx_valid`=0, `rx_level`=0, `busy`=0, all error flags 0, FSM in IDLE, FIFO pointers 0.
- **Input latency:** 2 cycles from `ser_rx` to `rx_s`.
- **Sample points,** counted from the cycle the falling edge is detected (cycle 0):
  - start bit at floor(D/2);
  - data bit n at floor(D/2) + (n+1)·D;
  - stop bit at floor(D/2) + 9·D (10·D with parity).
- **Output latency:** `rx_valid` and `rx_level` update on the cycle after the stop sample.
- **Pop:** the FIFO head advances on the clock edge where `rx_valid & rx_ready` is high.
- **Flags:** set on the cycle after the offending sample.
- **Back-to-back frames:** the FSM is back in IDLE one cycle after the stop sample. A start edge arriving half a bit later is caught.

## Configuration

- **`UART_RX_PARITY_EN` defined:** an even-parity bit is expected between D7 and stop. The PARITY state exists and `parity_err` is live. A frame is 11 bits.
- **Not defined:** 8N1 only. There is no PARITY state and `parity_err` is constant 0. A frame is 10 bits.

## Test plan

- **Single byte:** reset, `enable`=1, D=8, send 0xA5 8N1, `rx_ready`=0. `rx_valid` rises 1 cycle after the stop sample, `rx_data`=0xA5, `rx_level`=1. Pulse `rx_ready`: `rx_valid`=0, `rx_data`=0.
- **Overrun:** D=8, `rx_ready`=0, send 0x01..0x05 back to back with DEPTH=4. `rx_level`=4 and `overrun`=1. Popping yields 0x01–0x04; 0x05 is lost. A `clear_err` pulse returns `overrun` to 0.
- **Framing and break:** send 0x3C with stop=0. `frame_err`=1, `rx_level` unchanged. Then hold the line low for 30 bit times: no further bytes and no spurious start. Release the line, send 0x55: received correctly.
- **Glitch rejection:** a 2-cycle low pulse on `ser_rx` with D=16 causes a false start. `busy` returns to 0, no byte, no flags.
- **Reset and enable mid-frame:**
  - Assert `core_rstn`=0 during data bit 4. All outputs read reset values asynchronously.
  - Deassert `enable` during data bit 4. The FSM returns to IDLE, the FIFO is retained, no flags are set.
- **Parity (macro defined):** send 0x07 with parity 1 → accepted. Send 0x07 with parity 0 → `parity_err`=1, byte dropped.
